// File: rtl/reg_scoreboard.sv
// Register-file hazard scoreboard: per-register counts of writes in flight between
// issue and writeback, producing the decode stall and a running in-flight total.
module reg_scoreboard #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic        issue_we,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    output logic        stall,
    output logic        issue_accept,
    output logic [31:0] pending,
    output logic [3:0]  inflight,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [31:0]      pending_q, pending_d;
    logic [3:0]       inflight_q, inflight_d;
    logic             err_q, err_d;

    logic haz1, haz2, cap_haz;
    logic inc_any, dec_any;
    logic inc_done, dec_done;

    // Stall looks only at registered counts: the RF has no write-to-read bypass,
    // so a writeback in this cycle must not release the reader until the next one.
    always_comb begin
        haz1         = rs1_used && (rs1_addr != 5'd0) && (cnt_q[rs1_addr] != '0);
        haz2         = rs2_used && (rs2_addr != 5'd0) && (cnt_q[rs2_addr] != '0);
        cap_haz      = issue_we && (issue_rd != 5'd0) && (cnt_q[issue_rd] == CNT_MAX);
        stall        = issue_valid && (haz1 || haz2 || cap_haz);
        issue_accept = issue_valid && !stall;
    end

    always_comb begin
        cnt_d      = cnt_q;
        err_d      = err_q;
        inflight_d = inflight_q;
        pending_d  = '0;
        inc_done   = 1'b0;
        dec_done   = 1'b0;
        inc_any    = issue_accept && issue_we && (issue_rd != 5'd0);
        dec_any    = wb_we && (wb_rd != 5'd0);

        // Issue and writeback to the same register cancel out before any bound check.
        for (int r = 1; r < 32; r++) begin
            if (inc_any && (issue_rd == 5'(r)) && !(dec_any && (wb_rd == 5'(r)))) begin
                if (cnt_q[r] == CNT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + CNT_W'(1);
                    inc_done = 1'b1;
                end
            end
            if (dec_any && (wb_rd == 5'(r)) && !(inc_any && (issue_rd == 5'(r)))) begin
                if (cnt_q[r] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
                    dec_done = 1'b1;
                end
            end
        end
        cnt_d[0] = '0;

        if (inc_done && !dec_done && (inflight_q != 4'hF)) begin
            inflight_d = inflight_q + 4'd1;
        end else if (dec_done && !inc_done && (inflight_q != 4'h0)) begin
            inflight_d = inflight_q - 4'd1;
        end

        for (int r = 1; r < 32; r++) begin
            pending_d[r] = (cnt_d[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            pending_q  <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign pending  = pending_q;
    assign inflight = inflight_q;
    assign err      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios plus randomized traffic,
// every cycle compared against a per-register count model.
module tb_reg_scoreboard;

    localparam int MAXI = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_we, rs1_used, rs2_used, wb_we;
    logic [4:0]  issue_rd, rs1_addr, rs2_addr, wb_rd;
    logic        stall, issue_accept, err;
    logic [31:0] pending;
    logic [3:0]  inflight;

    always #5 clk = ~clk;

    reg_scoreboard #(.MAX_INFLIGHT(MAXI), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .wb_we(wb_we), .wb_rd(wb_rd),
        .stall(stall), .issue_accept(issue_accept),
        .pending(pending), .inflight(inflight), .err(err)
    );

    int checks = 0;
    int failures = 0;

    // Reference: outstanding-write count per architectural register.
    int mcnt [32];
    int minfl;
    bit merr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        minfl = 0;
        merr  = 1'b0;
    endtask

    function automatic logic [31:0] mpend();
        logic [31:0] p;
        p = '0;
        for (int r = 1; r < 32; r++) if (mcnt[r] > 0) p[r] = 1'b1;
        return p;
    endfunction

    task automatic step(input string tag, input logic v, input logic we, input logic [4:0] rd,
                        input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                        input logic u2, input logic wwe, input logic [4:0] wrd);
        bit es, ea, inc, dec;
        int delta;
        @(negedge clk);
        issue_valid = v;  issue_we = we;  issue_rd = rd;
        rs1_addr = a1;    rs1_used = u1;  rs2_addr = a2;  rs2_used = u2;
        wb_we = wwe;      wb_rd = wrd;
        #1;
        es = v && ((u1 && a1 != 0 && mcnt[a1] > 0) || (u2 && a2 != 0 && mcnt[a2] > 0) ||
                   (we && rd != 0 && mcnt[rd] >= MAXI));
        ea = v && !es;
        chk({tag, ".stall"},    {31'd0, stall},        {31'd0, es});
        chk({tag, ".accept"},   {31'd0, issue_accept}, {31'd0, ea});
        chk({tag, ".pending"},  pending,               mpend());
        chk({tag, ".inflight"}, {28'd0, inflight},     32'(minfl));
        chk({tag, ".err"},      {31'd0, err},          {31'd0, merr});
        inc   = ea && we && rd != 0;
        dec   = wwe && wrd != 0;
        delta = 0;
        if (!(inc && dec && rd == wrd)) begin
            if (inc) begin
                if (mcnt[rd] == MAXI) merr = 1'b1;
                else begin mcnt[rd]++; delta++; end
            end
            if (dec) begin
                if (mcnt[wrd] == 0) merr = 1'b1;
                else begin mcnt[wrd]--; delta--; end
            end
        end
        minfl = minfl + delta;
        if (minfl > 15) minfl = 15;
        if (minfl < 0) minfl = 0;
        @(posedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        issue_valid = 0; issue_we = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
        rs1_used = 0; rs2_used = 0; wb_we = 0; wb_rd = 0;
        mreset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        idle("reset_idle");
        step("free_read", 1, 0, 0, 5, 1, 0, 0, 0, 0);

        // Load-use: issue x5, consumer waits until the cycle after writeback.
        step("lu_issue", 1, 1, 5, 0, 0, 0, 0, 0, 0);
        step("lu_c1",    1, 0, 0, 5, 1, 0, 0, 0, 0);
        step("lu_c2",    1, 0, 0, 5, 1, 0, 0, 0, 0);
        step("lu_c3_wb", 1, 0, 0, 5, 1, 0, 0, 1, 5);
        chk("lu_c3_stall_seen", {31'd0, stall}, 32'd1);
        step("lu_c4",    1, 0, 0, 5, 1, 0, 0, 0, 0);
        chk("lu_c4_stall_clear", {31'd0, stall}, 32'd0);

        // Capacity on x7.
        step("cap_i1", 1, 1, 7, 0, 0, 0, 0, 0, 0);
        step("cap_i2", 1, 1, 7, 0, 0, 0, 0, 0, 0);
        step("cap_i3", 1, 1, 7, 0, 0, 0, 0, 0, 0);
        step("cap_i4", 1, 1, 7, 0, 0, 0, 0, 0, 0);
        chk("cap_full_stall", {31'd0, stall}, 32'd1);
        step("cap_i5_wb", 1, 1, 7, 0, 0, 0, 0, 1, 7);
        step("cap_i6",    1, 1, 7, 0, 0, 0, 0, 0, 0);
        chk("cap_after_wb_accept", {31'd0, issue_accept}, 32'd1);
        step("cap_d1", 0, 0, 0, 0, 0, 0, 0, 1, 7);
        step("cap_d2", 0, 0, 0, 0, 0, 0, 0, 1, 7);
        step("cap_d3", 0, 0, 0, 0, 0, 0, 0, 1, 7);

        // Same-cycle issue and writeback on x9.
        step("same_i",   1, 1, 9, 0, 0, 0, 0, 0, 0);
        step("same_iwb", 1, 1, 9, 0, 0, 0, 0, 1, 9);
        idle("same_hold");
        chk("same_cnt9_pending", {31'd0, pending[9]}, 32'd1);
        step("same_drain", 0, 0, 0, 0, 0, 0, 0, 1, 9);

        // x0 is never tracked.
        step("x0_issue", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("x0_read",  1, 0, 0, 0, 0, 0, 1, 0, 0);
        step("x0_wb",    0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle("x0_after");

        // Randomized traffic on x0..x7; writebacks only target outstanding registers.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] q [$];
            logic [4:0] wrd;
            logic       wwe;
            for (int r = 1; r < 8; r++) if (mcnt[r] > 0) q.push_back(5'(r));
            wwe = 1'b0;
            wrd = 5'($urandom_range(0, 7));
            if (q.size() > 0 && ($urandom % 3) != 0) begin
                wwe = 1'b1;
                wrd = q[$urandom % q.size()];
            end else if (($urandom % 8) == 0) begin
                wwe = 1'b1;
                wrd = 5'd0;
            end
            step("rand", ($urandom % 4) != 0, ($urandom % 4) != 0, 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                 wwe, wrd);
        end
        for (int r = 1; r < 8; r++) begin
            while (mcnt[r] > 0) step("rand_drain", 0, 0, 0, 0, 0, 0, 0, 1, 5'(r));
        end
        idle("rand_clean");

        // Writeback with nothing outstanding sets a sticky error.
        step("err_wb12", 0, 0, 0, 0, 0, 0, 0, 1, 12);
        idle("err_hold1");
        chk("err_sticky", {31'd0, err}, 32'd1);
        idle("err_hold2");

        // Saturate the running total, then back off one.
        for (int k = 0; k < 3; k++)
            for (int r = 10; r < 16; r++) step("sat_fill", 1, 1, 5'(r), 0, 0, 0, 0, 0, 0);
        idle("sat_top");
        chk("sat_inflight15", {28'd0, inflight}, 32'd15);
        step("sat_dec", 0, 0, 0, 0, 0, 0, 0, 1, 10);
        idle("sat_after");

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pending",  pending,              32'd0);
        chk("arst_inflight", {28'd0, inflight},    32'd0);
        chk("arst_err",      {31'd0, err},         32'd0);
        issue_valid = 1; issue_we = 0; rs1_addr = 5'd10; rs1_used = 1; wb_we = 0;
        #1;
        chk("arst_stall", {31'd0, stall}, 32'd0);
        mreset();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_read", 1, 0, 0, 10, 1, 11, 1, 0, 0);
        idle("post_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
